// File: rtl/bus_arbiter.sv
// bus_arbiter: three-master round-robin arbiter in front of one shared
// Wishbone-style slave bus. It adds one dead cycle between owners, gives no
// pre-emption, and raises a per-master error on a decoder fault or on a
// strobe timeout.
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  m_cyc_i,
    input  logic [2:0]  m_stb_i,
    input  logic [2:0]  m_we_i,
    input  logic [95:0] m_adr_i,
    input  logic [95:0] m_dat_i,
    input  logic [11:0] m_sel_i,
    output logic [2:0]  m_ack_o,
    output logic [2:0]  m_err_o,
    output logic [31:0] m_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        fault_i,
    output logic [2:0]  grant_o
);

    localparam int NUM_M = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = 4;
    // The last waiting cycle before a timeout. The error fires on the
    // TIMEOUT-th strobe cycle that has no response.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [1:0]       last_q,  last_d;
    logic [7:0]       wait_q,  wait_d;

    logic             stb_raw;
    logic             bus_ack;
    logic             bus_err;
    logic [1:0]       cand;
    logic             found;

    // State register: FSM state, one-hot owner, round-robin pointer, wait counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 2'd2;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    // Next state: the IDLE state does a round-robin pick starting after last.
    // The OWNED state releases the bus when the owner drops cyc.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wait_d  = '0;
        cand    = '0;
        found   = 1'b0;
        case (state_q)
            IDLE: begin
                for (int i = 1; i <= NUM_M; i++) begin
                    cand = 2'((int'(last_q) + i) % NUM_M);
                    if (!found && m_cyc_i[cand]) begin
                        found          = 1'b1;
                        state_d        = OWNED;
                        grant_d        = '0;
                        grant_d[cand]  = 1'b1;
                        last_d         = cand;
                    end
                end
            end
            OWNED: begin
                if (!(|(m_cyc_i & grant_q))) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (s_stb_o && !bus_ack && !bus_err) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: mux the owner's request onto the shared bus. A fault masks
    // the strobe toward the slave and turns the cycle into an error.
    always_comb begin
        stb_raw = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (grant_q[k]) begin
                stb_raw = m_stb_i[k];
                s_we_o  = m_we_i[k];
                s_adr_o = m_adr_i[AW*k +: AW];
                s_dat_o = m_dat_i[DW*k +: DW];
                s_sel_o = m_sel_i[SW*k +: SW];
            end
        end
        s_cyc_o = (state_q == OWNED);
        s_stb_o = stb_raw & ~fault_i;
        bus_ack = s_stb_o & s_ack_i;
        // An ack that lands on the timeout cycle wins, so the timeout requires no ack.
        bus_err = (stb_raw & fault_i) |
                  (s_stb_o & ~s_ack_i & (wait_q == TMO_LAST));
        m_ack_o = grant_q & {NUM_M{bus_ack}};
        m_err_o = grant_q & {NUM_M{bus_err}};
        m_dat_o = s_dat_i;
        grant_o = grant_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios followed by randomized traffic. Both are
// checked against a transaction-level model that keeps the owner and the last
// winner as integers and derives every expected output from them.
module tb_bus_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  m_cyc, m_stb, m_we;
    logic [95:0] m_adr, m_dat;
    logic [11:0] m_sel;
    logic [2:0]  m_ack, m_err, grant;
    logic [31:0] m_rdat, s_adr, s_wdat, s_rdat;
    logic        s_cyc, s_stb, s_we, s_ack, fault;
    logic [3:0]  s_sel;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // reference model state
    int mo = -1;   // owner index, -1 when idle
    int ml = 2;    // most recent winner
    int mw = 0;    // strobe cycles waited without response
    bit e_stb, e_ack, e_err;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .fault_i(fault),
        .grant_o(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Work out what the bus must show from the model owner and the current inputs.
    task automatic compare_all(input string pfx);
        logic [2:0]  eg;
        logic [31:0] ead, edt;
        logic [3:0]  esl;
        bit          ec, ew, raw;
        eg = '0; ead = '0; edt = '0; esl = '0; ec = 0; ew = 0; raw = 0;
        if (mo >= 0) begin
            eg  = 3'b001 << mo;
            ec  = 1;
            raw = m_stb[mo];
            ew  = m_we[mo];
            ead = m_adr[mo*32 +: 32];
            edt = m_dat[mo*32 +: 32];
            esl = m_sel[mo*4 +: 4];
        end
        e_stb = raw && !fault;
        e_ack = e_stb && s_ack;
        e_err = (raw && fault) || (e_stb && !s_ack && mw == TO - 1);
        check({pfx, ".grant"}, grant,  eg);
        check({pfx, ".s_cyc"}, s_cyc,  ec);
        check({pfx, ".s_stb"}, s_stb,  e_stb);
        check({pfx, ".s_we"},  s_we,   ew);
        check({pfx, ".s_adr"}, s_adr,  ead);
        check({pfx, ".s_dat"}, s_wdat, edt);
        check({pfx, ".s_sel"}, s_sel,  esl);
        check({pfx, ".m_ack"}, m_ack,  e_ack ? eg : 3'b000);
        check({pfx, ".m_err"}, m_err,  e_err ? eg : 3'b000);
        check({pfx, ".m_dat"}, m_rdat, s_rdat);
    endtask

    // Advance the model across one rising edge, using the inputs held during the cycle.
    task automatic model_edge();
        bit got;
        if (rst) begin
            mo = -1; ml = 2; mw = 0;
        end else if (mo < 0) begin
            got = 0;
            for (int i = 1; i <= 3; i++) begin
                if (!got && m_cyc[(ml + i) % 3]) begin
                    got = 1;
                    mo  = (ml + i) % 3;
                end
            end
            if (got) ml = mo;
            mw = 0;
        end else if (!m_cyc[mo]) begin
            mo = -1; mw = 0;
        end else begin
            mw = (e_stb && !e_ack && !e_err) ? mw + 1 : 0;
        end
    endtask

    // One cycle: compare mid-cycle, take the edge, then settle 1 time unit past it.
    task automatic step(input string tag);
        #2;
        compare_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
        m_sel = '0; s_rdat = '0; s_ack = 0; fault = 0;
        @(posedge clk);
        model_edge();
        #1;
        step("reset");
        check("reset.grant_zero", grant, 3'b000);
        check("reset.cyc_zero", s_cyc, 1'b0);

        // round-robin order with a dead cycle between owners
        rst = 0; m_cyc = 3'b111;
        step("rr.req");
        #1 check("rr.g0", grant, 3'b001);
        check("rr.cyc", s_cyc, 1'b1);
        m_cyc = 3'b110; step("rr.drop0");
        #1 check("rr.dead0", grant, 3'b000);
        step("rr.idle0");
        #1 check("rr.g1", grant, 3'b010);
        m_cyc = 3'b101; step("rr.drop1");
        step("rr.idle1");
        #1 check("rr.g2", grant, 3'b100);
        m_cyc = 3'b011; step("rr.drop2");
        step("rr.idle2");
        #1 check("rr.g0b", grant, 3'b001);

        // owner 1 read with ack
        m_cyc = 3'b010; step("rd.drop0");
        step("rd.idle");
        m_stb = 3'b010; m_adr[63:32] = 32'h2000_0800; s_ack = 1; s_rdat = 32'hDEAD_BEEF;
        #2 check("rd.ack", m_ack, 3'b010);
        check("rd.data", m_rdat, 32'hDEAD_BEEF);
        check("rd.adr", s_adr, 32'h2000_0800);
        step("rd");

        // an ack while the strobe is low is ignored
        m_stb = 3'b000;
        #2 check("noack.ack", m_ack, 3'b000);
        step("noack");

        // decoder fault
        m_stb = 3'b010; m_adr[63:32] = 32'h1000_0000; fault = 1; s_ack = 1;
        #2 check("fault.err", m_err, 3'b010);
        check("fault.stb", s_stb, 1'b0);
        check("fault.ack", m_ack, 3'b000);
        step("fault");

        // timeout on every 4th silent strobe cycle
        fault = 0; s_ack = 0;
        for (int c = 1; c <= 8; c++) begin
            #2 check($sformatf("tmo.c%0d", c), m_err, (c % 4 == 0) ? 3'b010 : 3'b000);
            step("tmo");
        end

        // reset mid-transfer while master 2 owns the bus
        m_cyc = 3'b100; m_stb = 3'b100;
        step("mid.drop1");
        step("mid.idle");
        #1 check("mid.g2", grant, 3'b100);
        step("mid.xfer");
        rst = 1;
        step("mid.rst");
        check("mid.grant0", grant, 3'b000);
        check("mid.cyc0", s_cyc, 1'b0);
        rst = 0; m_cyc = 3'b111;
        step("mid.req");
        #1 check("mid.first0", grant, 3'b001);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 3) == 0) m_cyc[k] = ~m_cyc[k];
            m_stb  = 3'($urandom);
            m_we   = 3'($urandom);
            m_adr  = {$urandom, $urandom, $urandom};
            m_dat  = {$urandom, $urandom, $urandom};
            m_sel  = 12'($urandom);
            s_rdat = $urandom;
            s_ack  = ($urandom_range(0, 2) == 0);
            fault  = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
